// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register over a req/gnt/rvalid memory port.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall event counters.
module fetch_stage #(
  parameter int                 XLEN      = 32,
  parameter logic [XLEN-1:0]    RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0]    NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
`endif
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [6:0]      opcode,
  output logic [2:0]      fun3,
  output logic            fun7
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;

  state_t          state, state_next;
  logic            drop, drop_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] skid, skid_next;
  logic            load;
  logic [XLEN-1:0] load_instr;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    drop_next  = drop;
    pc_next    = pc;
    skid_next  = skid;
    load       = 1'b0;
    load_instr = skid;
    if (redirect) begin
      pc_next = {redirect_pc[XLEN-1:2], 2'b00};
      unique case (state)
        S_REQ: begin
          if (imem_gnt) begin
            state_next = S_WAIT;
            drop_next  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_next = S_REQ;
            drop_next  = 1'b0;
          end else begin
            drop_next = 1'b1;
          end
        end
        default: state_next = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem_gnt) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop_next  = 1'b0;
              state_next = S_REQ;
            end else if (!stall) begin
              load       = 1'b1;
              load_instr = imem_rdata;
              pc_next    = pc + XLEN'(4);
              state_next = S_REQ;
            end else begin
              skid_next  = imem_rdata;
              state_next = S_FULL;
            end
          end
        end
        default: begin
          if (!stall) begin
            load       = 1'b1;
            pc_next    = pc + XLEN'(4);
            state_next = S_REQ;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      drop  <= 1'b0;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      drop  <= drop_next;
      pc    <= pc_next;
    end
  end

  // NOTE: the skid buffer is pure datapath; its emptiness is carried by the state, so it needs no reset.
  always_ff @(posedge clk) begin
    skid <= skid_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
    end else if (redirect) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (load) begin
      if_valid <= 1'b1;
      if_instr <= load_instr;
      if_pc    <= pc;
    end else if (!stall) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (load)              perf_fetched <= perf_fetched + 32'd1;
      if (stall && if_valid) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

  // Request is withheld during the reset cycle regardless of the pre-reset state.
  assign imem_req    = (state == S_REQ) && !rst;
  assign imem_addr   = pc;
  assign if_pc_plus4 = if_pc + XLEN'(4);
  assign opcode      = if_instr[6:0];
  assign fun3        = if_instr[14:12];
  assign fun7        = if_instr[30];

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage and IF/ID pipeline register.
- Sits directly upstream of the control unit and feeds it opcode, fun3 and fun7.
- Owns the PC and fetches over a req/gnt/rvalid instruction-memory interface with one request outstanding.
- Holds the fetched instruction under hazard stall; flushes on branch/jal/jalr redirect.

Parameters:
- XLEN, 32, width of PC and instruction.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr when the slot is empty or flushed (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request
- imem_addr  output  XLEN  fetch address, word aligned
- imem_gnt  input  1  request accepted this cycle
- imem_rvalid  input  1  response data valid
- imem_rdata  input  XLEN  response instruction
- stall  input  1  downstream hazard stall; hold IF/ID contents
- redirect  input  1  taken branch/jal/jalr; flush and refetch
- redirect_pc  input  XLEN  target PC; bits [1:0] ignored and forced to 0
- if_valid  output  1  IF/ID slot holds a live instruction
- if_instr  output  XLEN  IF/ID instruction
- if_pc  output  XLEN  PC of if_instr
- if_pc_plus4  output  XLEN  if_pc + 4, modulo 2^XLEN
- opcode  output  7  if_instr[6:0]
- fun3  output  3  if_instr[14:12]
- fun7  output  1  if_instr[30]

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst).
- Reset: pc=RESET_PC, state=REQ, drop=0, imem_req=0 in the reset cycle, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus4=4, buffer empty.
- opcode/fun3/fun7 are combinational slices of the registered if_instr.
- REQ: imem_req=1, imem_addr=pc. If imem_gnt=1, go to WAIT; otherwise stay in REQ.
- WAIT: imem_req=0. On imem_rvalid:
  - If drop=1: discard the data, clear drop, go to REQ.
  - Else if slot free (stall=0): load IF/ID with {rdata, pc}, pc+=4, go to REQ.
  - Else: capture rdata into the skid buffer, go to FULL.
- FULL: imem_req=0. When stall=0: move buffer into IF/ID, pc+=4, go to REQ.
- IF/ID consumption: any cycle with stall=0 and no load, if_valid<=0 and if_instr<=NOP_INSTR. With stall=1, IF/ID holds all values.
- Latency: gnt at cycle N, rvalid at N+k (k>=1), if_valid=1 at N+k+1. Peak throughput is one instruction per 2 cycles.
- Redirect (priority over stall and all other events):
  - IF/ID is flushed: if_valid<=0, if_instr<=NOP_INSTR.
  - pc<={redirect_pc[XLEN-1:2],2'b00}.
  - The skid buffer is discarded.
  - Next state by current state:
    - REQ without gnt: go to REQ. imem_addr changes next cycle; the memory tolerates request withdrawal without a gnt.
    - REQ with gnt in the same cycle: go to WAIT with drop=1.
    - WAIT without rvalid: stay in WAIT with drop=1.
    - WAIT with rvalid in the same cycle: data discarded, go to REQ.
    - FULL: go to REQ.
- Back-to-back redirects: the last one wins. drop stays 1 until the single outstanding response returns.
- Exactly one outstanding request at all times; imem_req is never high in WAIT or FULL.
- rst asserted mid-operation: returns to reset values. Any late rvalid from before reset is ignored, because the state is REQ, not WAIT.
- rvalid outside WAIT/FULL-pending (REQ, or in FULL) is a protocol error and is ignored.
- PC wrap: 32'hFFFF_FFFC + 4 = 0, no flag.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - Adds outputs perf_fetched (32) and perf_stall (32), both reset to 0, each wrapping at 2^32.
  - perf_fetched increments on every IF/ID load.
  - perf_stall increments every cycle with stall=1 and if_valid=1.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, memory grants immediately, rvalid 1 cycle after gnt, data 0x00500093 at 0x0 -> if_valid at cycle 3, opcode=0x13, fun3=0, if_pc=0, if_pc_plus4=4; next imem_addr=0x4.
- stall=1 for 4 cycles while if_valid=1 and a second response arrives -> IF/ID holds the first instruction; the second goes to the buffer (FULL, no imem_req); when stall drops, the second instruction appears with if_pc=0x4.
- redirect to 0x100 while in WAIT, then rvalid with 0xDEADBEEF -> data dropped, if_valid stays 0, next imem_addr=0x100.
- redirect_pc=0x203 while stall=1 -> IF/ID flushed to NOP_INSTR, if_valid=0, fetch at 0x200.
- imem_gnt low for 5 cycles -> imem_req and imem_addr steady; if_valid=0 throughout.
- rst in FULL with stall=1, then late rvalid -> all outputs at reset values; the stale data never reaches IF/ID.
